// File: rtl/prescaled_counter_bank_if.sv
// Control/observation bundle for prescaled_counter_bank: count/load requests in,
// flattened channel counts and terminal-count pulses out.
interface prescaled_counter_bank_if #(
    parameter int WIDTH    = 64,
    parameter int CHANNELS = 2,
    parameter int SEL_W    = 1
);
    logic                      En;
    logic [SEL_W-1:0]          Slt;
    logic                      Dir;
    logic                      Load;
    logic [WIDTH-1:0]          LoadVal;
    logic [CHANNELS*WIDTH-1:0] Count;
    logic [CHANNELS-1:0]       Tc;

    modport master (
        output En, Slt, Dir, Load, LoadVal,
        input  Count, Tc
    );

    modport slave (
        input  En, Slt, Dir, Load, LoadVal,
        output Count, Tc
    );
endinterface

// File: rtl/prescaled_counter_bank.sv
// Bank of up/down counters with per-channel power-of-two prescalers, load and TC pulse.
// Optional macro PRESCALED_COUNTER_SATURATE_EN: clamp at the ends instead of wrapping.
module prescaled_counter_bank #(
    parameter int WIDTH    = 64,
    parameter int CHANNELS = 2,
    parameter int SEL_W    = 1,
    parameter int PS_LOG2  = 2
) (
    input  logic                    Clk,
    input  logic                    Reset,
    prescaled_counter_bank_if.slave bus
);

    // Next value for a step; a wrapping step either wraps modulo 2**WIDTH or holds.
    function automatic logic [WIDTH-1:0] step_value(input logic [WIDTH-1:0] cur,
                                                    input logic             down);
        logic [WIDTH-1:0] nxt;
        nxt = down ? cur - 1'b1 : cur + 1'b1;
`ifdef PRESCALED_COUNTER_SATURATE_EN
        if (wraps(cur, down))
            nxt = cur;
`endif
        return nxt;
    endfunction

    function automatic logic wraps(input logic [WIDTH-1:0] cur, input logic down);
        return down ? (cur == '0) : (cur == '1);
    endfunction

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_ch
            localparam int  PS_BITS = i * PS_LOG2;
            localparam int  PW      = (PS_BITS > 0) ? PS_BITS : 1;
            localparam bit  DIV1    = (PS_BITS == 0);

            logic [PW-1:0]    ps_p0;
            logic [WIDTH-1:0] count_p0;
            logic             tc_p0;
            logic             sel;
            logic             event_q;
            logic             ps_full;
            logic             step;

            assign sel     = (bus.Slt == SEL_W'(i));
            assign event_q = bus.En && !bus.Load && sel;
            assign ps_full = DIV1 || (ps_p0 == '1);
            assign step    = event_q && ps_full;

            // Stage p0: prescaler, counter and terminal-count registers
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    ps_p0    <= '0;
                    count_p0 <= '0;
                    tc_p0    <= 1'b0;
                end else if (bus.Load && sel) begin
                    ps_p0    <= '0;
                    count_p0 <= bus.LoadVal;
                    tc_p0    <= 1'b0;
                end else if (event_q) begin
                    ps_p0 <= ps_full ? '0 : ps_p0 + 1'b1;
                    if (step)
                        count_p0 <= step_value(count_p0, bus.Dir);
                    tc_p0 <= step && wraps(count_p0, bus.Dir);
                end else begin
                    tc_p0 <= 1'b0;
                end
            end

            assign bus.Count[i*WIDTH +: WIDTH] = count_p0;
            assign bus.Tc[i]                   = tc_p0;
        end
    endgenerate

endmodule

// File: tb/tb_prescaled_counter_bank.sv
// Directed bench for prescaled_counter_bank (WIDTH=8, CHANNELS=2, PS_LOG2=2).
module tb_prescaled_counter_bank;
    localparam int WIDTH    = 8;
    localparam int CHANNELS = 2;
    localparam int SEL_W    = 1;
    localparam int PS_LOG2  = 2;

    logic Clk = 1'b0;
    logic Reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    prescaled_counter_bank_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) bus ();

    prescaled_counter_bank #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W), .PS_LOG2(PS_LOG2)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    function automatic logic [7:0] c0();
        return bus.Count[7:0];
    endfunction

    function automatic logic [7:0] c1();
        return bus.Count[15:8];
    endfunction

    initial begin
        Reset       = 1'b1;
        bus.En      = 1'b0;
        bus.Slt     = '0;
        bus.Dir     = 1'b0;
        bus.Load    = 1'b0;
        bus.LoadVal = '0;
        tick(2);
        check_eq("rst_c0", c0(), 8'h00);
        check_eq("rst_c1", c1(), 8'h00);
        check_eq("rst_tc", bus.Tc, 2'b00);
        Reset = 1'b0;

        // channel 0 counts every event
        bus.En = 1'b1; bus.Slt = 1'b0; bus.Dir = 1'b0;
        tick(10);
        bus.En = 1'b0;
        check_eq("up10_c0", c0(), 8'd10);
        check_eq("up10_c1", c1(), 8'd0);
        check_eq("up10_tc", bus.Tc, 2'b00);

        // channel 1 steps every 4th event
        bus.En = 1'b1; bus.Slt = 1'b1;
        tick(3);
        check_eq("ps_ev3_c1", c1(), 8'd0);
        tick(1);
        check_eq("ps_ev4_c1", c1(), 8'd1);
        tick(8);
        bus.En = 1'b0;
        check_eq("ps_ev12_c1", c1(), 8'd3);
        check_eq("ps_ev12_c0", c0(), 8'd10);

        // load near top then wrap up
        bus.Slt = 1'b0; bus.Load = 1'b1; bus.LoadVal = 8'hFE;
        tick(1);
        bus.Load = 1'b0;
        check_eq("ld_fe_c0", c0(), 8'hFE);
        check_eq("ld_fe_tc", bus.Tc, 2'b00);
        bus.En = 1'b1;
        tick(1);
        check_eq("up_ff_c0", c0(), 8'hFF);
        check_eq("up_ff_tc", bus.Tc, 2'b00);
        tick(1);
        bus.En = 1'b0;
`ifdef PRESCALED_COUNTER_SATURATE_EN
        check_eq("up_wrap_c0", c0(), 8'hFF);
`else
        check_eq("up_wrap_c0", c0(), 8'h00);
`endif
        check_eq("up_wrap_tc", bus.Tc, 2'b01);
        tick(1);
        check_eq("up_post_tc", bus.Tc, 2'b00);

        // load zero then step down
        bus.Load = 1'b1; bus.LoadVal = 8'h00;
        tick(1);
        bus.Load = 1'b0; bus.En = 1'b1; bus.Dir = 1'b1;
        tick(1);
        bus.En = 1'b0; bus.Dir = 1'b0;
`ifdef PRESCALED_COUNTER_SATURATE_EN
        check_eq("dn_wrap_c0", c0(), 8'h00);
`else
        check_eq("dn_wrap_c0", c0(), 8'hFF);
`endif
        check_eq("dn_wrap_tc", bus.Tc, 2'b01);
        tick(1);
        check_eq("dn_post_tc", bus.Tc, 2'b00);

        // load overrides concurrent count and clears the prescaler
        bus.En = 1'b1; bus.Slt = 1'b1;
        tick(2);
        bus.Load = 1'b1; bus.LoadVal = 8'h05;
        tick(1);
        bus.Load = 1'b0;
        check_eq("ld_en_c1", c1(), 8'h05);
        check_eq("ld_en_tc", bus.Tc, 2'b00);
        tick(3);
        check_eq("ld_ev3_c1", c1(), 8'h05);
        tick(1);
        check_eq("ld_ev4_c1", c1(), 8'h06);

        // En gaps and Dir changes keep prescaler progress
        tick(2);
        bus.En = 1'b0;
        tick(1);
        bus.En = 1'b1; bus.Dir = 1'b1;
        tick(1);
        check_eq("dir_ev3_c1", c1(), 8'h06);
        tick(1);
        bus.En = 1'b0; bus.Dir = 1'b0;
        check_eq("dir_ev4_c1", c1(), 8'h05);

        // reset mid-prescale beats load and en
        bus.En = 1'b1;
        tick(2);
        Reset = 1'b1; bus.Load = 1'b1; bus.LoadVal = 8'hAA;
        tick(1);
        Reset = 1'b0; bus.Load = 1'b0;
        check_eq("rst2_c0", c0(), 8'h00);
        check_eq("rst2_c1", c1(), 8'h00);
        check_eq("rst2_tc", bus.Tc, 2'b00);
        tick(3);
        check_eq("rst2_ev3_c1", c1(), 8'h00);
        tick(1);
        bus.En = 1'b0;
        check_eq("rst2_ev4_c1", c1(), 8'h01);
        check_eq("rst2_ev4_c0", c0(), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/prescaled_counter_bank.md
Name: prescaled_counter_bank

Overview:
- Bank of CHANNELS independent up/down counters, each WIDTH bits wide; successor to the two-output select counter.
- Slt steers enabled count events to one channel.
- Each channel has its own power-of-two prescaler, supports synchronous load, and flags terminal count.
- Used as the general event/cycle counter for datapath experiments and timing measurement.

Parameters:
- WIDTH, 64, bit width of each channel counter.
- CHANNELS, 2, number of channels (2..8).
- SEL_W, 1, width of Slt; must satisfy 2**SEL_W >= CHANNELS.
- PS_LOG2, 2, prescale step. Channel i advances once per 2**(i*PS_LOG2) qualifying events.

Ports:
- Clk  in  1  rising-edge clock, sole clock.
- Reset  in  1  synchronous, active-high reset.
- En  in  1  count enable.
- Slt  in  SEL_W  channel select for count and load.
- Dir  in  1  0 = count up, 1 = count down; applies to the selected channel.
- Load  in  1  synchronous load of the selected channel.
- LoadVal  in  WIDTH  value loaded when Load=1.
- Count  out  CHANNELS*WIDTH  flattened counter values; channel i is at bits [i*WIDTH +: WIDTH]; registered.
- Tc  out  CHANNELS  terminal-count pulse per channel; registered.

Behaviour:
- Reset (synchronous, active-high): on a Clk edge with Reset=1, all Count=0, all Tc=0, all prescalers=0. Reset has highest priority.
- Qualifying event for channel i: En=1 && Load=0 && Slt==i. An Slt value >= CHANNELS selects nothing, and no state changes.
- Prescaler i:
  - Width max(1, i*PS_LOG2).
  - On each qualifying event it increments. When it equals 2**(i*PS_LOG2)-1 it wraps to 0, and that event is a step.
  - Channel 0 steps on every qualifying event.
  - The prescaler always counts up, independent of Dir.
- Step:
  - Dir=0: Count_i <= Count_i+1, modulo 2**WIDTH.
  - Dir=1: Count_i <= Count_i-1, modulo 2**WIDTH.
  - Latency: the new value is visible one cycle after the stepping edge (registered output).
- Wrap:
  - Up from all-ones to 0, or down from 0 to all-ones.
  - On the wrapping step, Tc[i]=1 for exactly one cycle; otherwise Tc[i]=0.
- Load (Load=1, Slt==i < CHANNELS):
  - Count_i <= LoadVal and prescaler i <= 0, regardless of En.
  - Tc[i]=0 that cycle. Load overrides any simultaneous count.
- Unselected channels hold their Count and prescaler value; their Tc is 0.
- En=0 or Dir changes do not disturb prescaler state.
- Reset mid-prescale discards partial prescale progress.
- Reset asserted together with Load: reset wins.

Optional Feature:
- Macro: PRESCALED_COUNTER_SATURATE_EN.
- Defined:
  - A step that would wrap is suppressed; Count holds all-ones (up) or 0 (down).
  - Tc[i] pulses for one cycle on every suppressed step attempt.
  - The prescaler still wraps normally.
- Undefined: modulo wrap exactly as described in Behaviour.

Test Plan (bench uses WIDTH=8, CHANNELS=2, SEL_W=1, PS_LOG2=2):
- Reset, then En=1, Slt=0, Dir=0 for 10 cycles -> Count0=10, Count1=0, Tc=0.
- Slt=1, En=1, Dir=0 for 12 cycles -> Count1=3 (steps on qualifying events 4, 8, 12), Count0 unchanged.
- Load=1, Slt=0, LoadVal=8'hFE, then 2 up events on channel 0 -> Count0=FF then 00; Tc[0]=1 only in the cycle Count0 becomes 00.
- Load=1, Slt=0, LoadVal=8'h00, then 1 down event -> macro undefined: Count0=FF, Tc[0] pulse. Macro defined: Count0 stays 00, Tc[0] pulse.
- En=1, Slt=1 for 2 events, then Load=1 with LoadVal=8'h05 in the same cycle as En=1 -> Count1=05, prescaler cleared; 4 further events give Count1=06.
- Reset asserted mid-count with Load=1 and En=1 -> next cycle all Count=0 and Tc=0; subsequent counting restarts from a cleared prescaler.
